alu_pipe: RTL and testbench

- Parametrised, pipelined successor of the Hack combinational ALU, for the next CPU datapath revision.
- Keeps the Hack operand controls (zx/nx/zy/ny/no) and generalises f into a 2-bit op (AND/ADD/OR/XOR).
- Adds a valid/ready handshake, a 2-stage pipeline with backpressure, and carry/overflow flags.
- Optionally includes an iterative multi-cycle multiplier.

---
 rtl/alu_pipe_if.sv | 56 +++++
 rtl/alu_pipe.sv | 245 ++++++++++++++++++++++++
 tb/tb_alu_pipe.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_pipe_if.sv
// alu_pipe_if: request/result bus of the pipelined ALU.
//
// Signal groups:
//   request : in_valid, in_ready, x, y, zx, nx, zy, ny, op, no
//             (plus mul when ALU_PIPE_MUL_EN is defined)
//   result  : out_valid, out_ready, out, zr, ng, cy, ov
//
// Modports:
//   slave  - the ALU side: consumes requests, produces results.
//   master - the requester/consumer side.
//
// Optional feature macro: ALU_PIPE_MUL_EN adds the mul request bit.
interface alu_pipe_if #(
  parameter int WIDTH = 16
);
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             zx;
  logic             nx;
  logic             zy;
  logic             ny;
  logic [1:0]       op;
  logic             no;
`ifdef ALU_PIPE_MUL_EN
  logic             mul;
`endif
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] out;
  logic             zr;
  logic             ng;
  logic             cy;
  logic             ov;

`ifdef ALU_PIPE_MUL_EN
  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, op, no, mul, out_ready,
    output in_ready, out_valid, out, zr, ng, cy, ov
  );
  modport master (
    output in_valid, x, y, zx, nx, zy, ny, op, no, mul, out_ready,
    input  in_ready, out_valid, out, zr, ng, cy, ov
  );
`else
  modport slave (
    input  in_valid, x, y, zx, nx, zy, ny, op, no, out_ready,
    output in_ready, out_valid, out, zr, ng, cy, ov
  );
  modport master (
    output in_valid, x, y, zx, nx, zy, ny, op, no, out_ready,
    input  in_ready, out_valid, out, zr, ng, cy, ov
  );
`endif
endinterface

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined Hack-style ALU with valid/ready handshake.
//
// Stage 1 registers the pre-processed operands (zero then invert), op and no.
// Stage 2 computes AND/ADD/OR/XOR, applies the output inversion and registers
// the result together with zr/ng/cy/ov. cy/ov describe the raw ADD, before
// the output inversion, and are 0 for logic ops.
//
// Ports:
//   clk   - clock, all state on the rising edge
//   rst_n - asynchronous active-low reset
//   bus   - alu_pipe_if slave modport (request and result handshakes)
//
// Optional feature macro: ALU_PIPE_MUL_EN
//   Adds an iterative shift-add multiplier. A request with mul=1 parks in
//   stage 1 while an IDLE->MUL->DONE->IDLE machine computes the low WIDTH
//   bits of xp*yp, one step per cycle; the product then flows into stage 2
//   like a normal result.
module alu_pipe #(
  parameter int WIDTH = 16
) (
  input  logic      clk,
  input  logic      rst_n,
  alu_pipe_if.slave bus
);

  localparam int MSB = WIDTH - 1;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_ADD = 2'b01;
  localparam logic [1:0] OP_OR  = 2'b10;
  localparam logic [1:0] OP_XOR = 2'b11;

  // Hack operand conditioning: zeroing happens before inversion.
  function automatic logic [WIDTH-1:0] prep_operand(input logic [WIDTH-1:0] v,
                                                    input logic zero,
                                                    input logic inv);
    logic [WIDTH-1:0] t;
    t = zero ? '0 : v;
    return inv ? ~t : t;
  endfunction

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_x_q, s1_x_d;
  logic [WIDTH-1:0] s1_y_q, s1_y_d;
  logic [1:0]       s1_op_q, s1_op_d;
  logic             s1_no_q, s1_no_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic             zr_q, zr_d;
  logic             ng_q, ng_d;
  logic             cy_q, cy_d;
  logic             ov_q, ov_d;

  logic             s2_free;
  logic             s1_done;
  logic             s1_advance;
  logic             in_ready;
  logic             accept;

  logic [WIDTH:0]   sum;
  logic [WIDTH-1:0] r;
  logic [WIDTH-1:0] res;
  logic             r_cy;
  logic             r_ov;

`ifdef ALU_PIPE_MUL_EN
  typedef enum logic [1:0] {ST_IDLE, ST_MUL, ST_DONE} mul_state_e;
  localparam int CW = $clog2(WIDTH);

  mul_state_e       state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
`endif

  // Handshake: stage 2 can take new data when empty or being drained, and
  // stage 1 can take a request when empty or when its content moves on this
  // cycle. A multiply blocks new requests until its product has left stage 1.
  always_comb begin
    s2_free = !out_valid_q || bus.out_ready;
`ifdef ALU_PIPE_MUL_EN
    s1_done  = s1_valid_q && (state_q != ST_MUL);
    s1_advance = s1_done && s2_free;
    in_ready = rst_n && (state_q == ST_IDLE) && (!s1_valid_q || s1_advance);
`else
    s1_done  = s1_valid_q;
    s1_advance = s1_done && s2_free;
    in_ready = rst_n && (!s1_valid_q || s1_advance);
`endif
    accept = bus.in_valid && in_ready;
  end

  // Stage 1 next state. While multiplying, the stage-1 operand registers are
  // reused as the shifting multiplicand (x) and multiplier (y).
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_x_d     = s1_x_q;
    s1_y_d     = s1_y_q;
    s1_op_d    = s1_op_q;
    s1_no_d    = s1_no_q;
`ifdef ALU_PIPE_MUL_EN
    state_d    = state_q;
    cnt_d      = cnt_q;
    acc_d      = acc_q;
`endif

    if (s1_advance) begin
      s1_valid_d = 1'b0;
    end

    if (accept) begin
      s1_valid_d = 1'b1;
      s1_x_d     = prep_operand(bus.x, bus.zx, bus.nx);
      s1_y_d     = prep_operand(bus.y, bus.zy, bus.ny);
      s1_op_d    = bus.op;
      s1_no_d    = bus.no;
    end

`ifdef ALU_PIPE_MUL_EN
    case (state_q)
      ST_IDLE: begin
        if (accept && bus.mul) begin
          state_d = ST_MUL;
          cnt_d   = '0;
          acc_d   = '0;
        end
      end
      ST_MUL: begin
        acc_d  = acc_q + (s1_y_q[0] ? s1_x_q : '0);
        s1_x_d = s1_x_q << 1;
        s1_y_d = s1_y_q >> 1;
        cnt_d  = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (s1_advance) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
`endif
  end

  // Stage 2 datapath: raw result and ADD flags, then the output inversion.
  always_comb begin
    sum  = {1'b0, s1_x_q} + {1'b0, s1_y_q};
    r    = '0;
    r_cy = 1'b0;
    r_ov = 1'b0;
    case (s1_op_q)
      OP_AND: r = s1_x_q & s1_y_q;
      OP_ADD: begin
        r    = sum[MSB:0];
        r_cy = sum[WIDTH];
        r_ov = (s1_x_q[MSB] == s1_y_q[MSB]) && (sum[MSB] != s1_x_q[MSB]);
      end
      OP_OR:  r = s1_x_q | s1_y_q;
      OP_XOR: r = s1_x_q ^ s1_y_q;
      default: r = '0;
    endcase
`ifdef ALU_PIPE_MUL_EN
    if (state_q == ST_DONE) begin
      r    = acc_q;
      r_cy = 1'b0;
      r_ov = 1'b0;
    end
`endif
    res = s1_no_q ? ~r : r;
  end

  // Stage 2 next state: result registers only change when stage 2 is free,
  // so a stalled result and its flags stay put.
  always_comb begin
    out_valid_d = out_valid_q;
    out_d       = out_q;
    zr_d        = zr_q;
    ng_d        = ng_q;
    cy_d        = cy_q;
    ov_d        = ov_q;
    if (s2_free) begin
      out_valid_d = s1_advance;
      if (s1_advance) begin
        out_d = res;
        zr_d  = (res == '0);
        ng_d  = res[MSB];
        cy_d  = r_cy;
        ov_d  = r_ov;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q  <= 1'b0;
      s1_x_q      <= '0;
      s1_y_q      <= '0;
      s1_op_q     <= '0;
      s1_no_q     <= 1'b0;
      out_valid_q <= 1'b0;
      out_q       <= '0;
      zr_q        <= 1'b0;
      ng_q        <= 1'b0;
      cy_q        <= 1'b0;
      ov_q        <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_x_q      <= s1_x_d;
      s1_y_q      <= s1_y_d;
      s1_op_q     <= s1_op_d;
      s1_no_q     <= s1_no_d;
      out_valid_q <= out_valid_d;
      out_q       <= out_d;
      zr_q        <= zr_d;
      ng_q        <= ng_d;
      cy_q        <= cy_d;
      ov_q        <= ov_d;
    end
  end

`ifdef ALU_PIPE_MUL_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      acc_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
    end
  end
`endif

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out       = out_q;
  assign bus.zr        = zr_q;
  assign bus.ng        = ng_q;
  assign bus.cy        = cy_q;
  assign bus.ov        = ov_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: scoreboard bench for alu_pipe at WIDTH=16.
//
// The driver pushes the hand-computed expected result when a request is
// accepted; an independent monitor on the falling edge compares whatever the
// DUT presents against the head of the queue, popping on a result transfer.
// Define ALU_PIPE_MUL_EN to also exercise the multiplier.
module tb_alu_pipe;

  localparam int W = 16;

  typedef struct {
    logic [W-1:0] x;
    logic [W-1:0] y;
    logic         zx, nx, zy, ny;
    logic [1:0]   op;
    logic         no;
    logic         mul;
  } req_t;

  typedef struct {
    string        name;
    logic [W-1:0] out;
    logic         zr, ng, cy, ov;
    int           lat;
    int           issued;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cyc;
  int   total;
  int   bad;
  exp_t exp_q[$];

  alu_pipe_if #(.WIDTH(W)) bus ();

  alu_pipe #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic req_t mkReq(input logic [W-1:0] x, input logic [W-1:0] y,
                                 input logic [3:0] ctl, input logic [1:0] op,
                                 input logic no, input logic mul);
    req_t r;
    r.x = x; r.y = y;
    r.zx = ctl[3]; r.nx = ctl[2]; r.zy = ctl[1]; r.ny = ctl[0];
    r.op = op; r.no = no; r.mul = mul;
    return r;
  endfunction

  function automatic exp_t mkExp(input string name, input logic [W-1:0] out,
                                 input logic zr, input logic ng,
                                 input logic cy, input logic ov, input int lat);
    exp_t e;
    e.name = name; e.out = out;
    e.zr = zr; e.ng = ng; e.cy = cy; e.ov = ov;
    e.lat = lat; e.issued = 0;
    return e;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act,
                             input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end
  endtask

  // Present one request until accepted (bounded), record its expectation.
  task automatic applyStimulus(input req_t r, input exp_t e);
    int waited;
    bus.in_valid = 1'b1;
    bus.x  = r.x;  bus.y  = r.y;
    bus.zx = r.zx; bus.nx = r.nx; bus.zy = r.zy; bus.ny = r.ny;
    bus.op = r.op; bus.no = r.no;
`ifdef ALU_PIPE_MUL_EN
    bus.mul = r.mul;
`endif
    waited = 0;
    @(negedge clk);
    while (!bus.in_ready && waited < 200) begin
      @(negedge clk);
      waited++;
    end
    if (!bus.in_ready) begin
      total++;
      bad++;
      $display("[TB] FAIL accept_timeout %s: in_ready 0 for 200 cycles, required 1", e.name);
    end else begin
      e.issued = cyc;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic waitDrain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      total++;
      bad++;
      $display("[TB] FAIL drain_timeout: %0d results outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
    @(posedge clk);
    #1;
  endtask

  // Monitor: compare the presented result to the oldest expectation; while
  // stalled, the held value is compared every cycle against the same entry.
  always @(negedge clk) begin
    if (rst_n && bus.out_valid) begin
      if (exp_q.size() == 0) begin
        if (bus.out_ready) begin
          total++;
          bad++;
          $display("[TB] FAIL unexpected_result: got out=0x%0h with nothing outstanding", bus.out);
        end
      end else begin
        checkOutput({exp_q[0].name, ".out"}, 32'(bus.out), 32'(exp_q[0].out));
        checkOutput({exp_q[0].name, ".zr"}, 32'(bus.zr), 32'(exp_q[0].zr));
        checkOutput({exp_q[0].name, ".ng"}, 32'(bus.ng), 32'(exp_q[0].ng));
        checkOutput({exp_q[0].name, ".cy"}, 32'(bus.cy), 32'(exp_q[0].cy));
        checkOutput({exp_q[0].name, ".ov"}, 32'(bus.ov), 32'(exp_q[0].ov));
        if (bus.out_ready) begin
          if (exp_q[0].lat > 0) begin
            checkOutput({exp_q[0].name, ".latency"}, 32'(cyc - exp_q[0].issued),
                        32'(exp_q[0].lat));
          end
          void'(exp_q.pop_front());
        end
      end
    end
  end

  req_t dir_req[8];
  exp_t dir_exp[8];

  initial begin
    rst_n = 1'b0;
    cyc = 0;
    total = 0;
    bad = 0;
    bus.in_valid = 1'b0;
    bus.x = '0; bus.y = '0;
    bus.zx = 1'b0; bus.nx = 1'b0; bus.zy = 1'b0; bus.ny = 1'b0;
    bus.op = 2'b00; bus.no = 1'b0;
`ifdef ALU_PIPE_MUL_EN
    bus.mul = 1'b0;
`endif
    bus.out_ready = 1'b1;

    // Directed table: ctl = {zx,nx,zy,ny}; op 00 AND, 01 ADD, 10 OR, 11 XOR.
    dir_req[0] = mkReq(16'h0011, 16'h0003, 4'b0000, 2'b01, 1'b0, 1'b0);
    dir_exp[0] = mkExp("add_basic", 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    dir_req[1] = mkReq(16'h0011, 16'h0003, 4'b0100, 2'b01, 1'b1, 1'b0);
    dir_exp[1] = mkExp("x_minus_y", 16'h000E, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    dir_req[2] = mkReq(16'h0011, 16'h0003, 4'b1111, 2'b01, 1'b1, 1'b0);
    dir_exp[2] = mkExp("const_one", 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0, 2);
    dir_req[3] = mkReq(16'h0011, 16'h0003, 4'b0000, 2'b00, 1'b0, 1'b0);
    dir_exp[3] = mkExp("and_basic", 16'h0001, 1'b0, 1'b0, 1'b0, 1'b0, 2);
    dir_req[4] = mkReq(16'h7FFF, 16'h0001, 4'b0000, 2'b01, 1'b0, 1'b0);
    dir_exp[4] = mkExp("add_ovf", 16'h8000, 1'b0, 1'b1, 1'b0, 1'b1, 2);
    dir_req[5] = mkReq(16'hFFFF, 16'h0001, 4'b0000, 2'b01, 1'b0, 1'b0);
    dir_exp[5] = mkExp("add_carry", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 2);
    dir_req[6] = mkReq(16'h00F0, 16'h0F0F, 4'b0000, 2'b10, 1'b1, 1'b0);
    dir_exp[6] = mkExp("nor", 16'hF000, 1'b0, 1'b1, 1'b0, 1'b0, 2);
    dir_req[7] = mkReq(16'hFFFF, 16'h0001, 4'b0000, 2'b11, 1'b0, 1'b0);
    dir_exp[7] = mkExp("xor", 16'hFFFE, 1'b0, 1'b1, 1'b0, 1'b0, 2);

    // Reset state.
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset.out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("reset.in_ready", 32'(bus.in_ready), 32'h0);
    checkOutput("reset.out", 32'(bus.out), 32'h0);
    checkOutput("reset.flags", {28'h0, bus.zr, bus.ng, bus.cy, bus.ov}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    $display("[TB] directed back-to-back vectors");
    for (int i = 0; i < 8; i++) applyStimulus(dir_req[i], dir_exp[i]);
    waitDrain();

    $display("[TB] stream with mid-stream backpressure");
    fork
      begin
        applyStimulus(mkReq(16'h0001, 16'h0002, 4'b0000, 2'b01, 1'b0, 1'b0),
                      mkExp("strm_a", 16'h0003, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        applyStimulus(mkReq(16'h1000, 16'h0234, 4'b0000, 2'b01, 1'b0, 1'b0),
                      mkExp("strm_b", 16'h1234, 1'b0, 1'b0, 1'b0, 1'b0, 0));
        applyStimulus(mkReq(16'h8000, 16'h8000, 4'b0000, 2'b01, 1'b0, 1'b0),
                      mkExp("strm_c", 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 0));
        applyStimulus(mkReq(16'h00FF, 16'h0F01, 4'b0000, 2'b01, 1'b0, 1'b0),
                      mkExp("strm_d", 16'h1000, 1'b0, 1'b0, 1'b0, 1'b0, 0));
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
          @(negedge clk);
          checkOutput("stall.in_ready", 32'(bus.in_ready), 32'h0);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
      end
    join
    waitDrain();

    $display("[TB] asynchronous reset with both stages full");
    bus.out_ready = 1'b0;
    applyStimulus(mkReq(16'h0005, 16'h0006, 4'b0000, 2'b01, 1'b0, 1'b0),
                  mkExp("pre_rst_a", 16'h000B, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    applyStimulus(mkReq(16'h0007, 16'h0008, 4'b0000, 2'b01, 1'b0, 1'b0),
                  mkExp("pre_rst_b", 16'h000F, 1'b0, 1'b0, 1'b0, 1'b0, 0));
    #2;
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    checkOutput("midrst.out_valid", 32'(bus.out_valid), 32'h0);
    checkOutput("midrst.out", 32'(bus.out), 32'h0);
    checkOutput("midrst.flags", {28'h0, bus.zr, bus.ng, bus.cy, bus.ov}, 32'h0);
    checkOutput("midrst.in_ready", 32'(bus.in_ready), 32'h0);
    @(negedge clk);
    bus.out_ready = 1'b1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(mkReq(16'h0011, 16'h0003, 4'b0000, 2'b01, 1'b0, 1'b0),
                  mkExp("post_rst", 16'h0014, 1'b0, 1'b0, 1'b0, 1'b0, 2));
    waitDrain();

`ifdef ALU_PIPE_MUL_EN
    $display("[TB] multiplier");
    applyStimulus(mkReq(16'h0011, 16'h0003, 4'b0000, 2'b01, 1'b0, 1'b1),
                  mkExp("mul", 16'h0033, 1'b0, 1'b0, 1'b0, 1'b0, W + 2));
    bus.in_valid = 1'b1;
    for (int k = 0; k < W + 1; k++) begin
      @(negedge clk);
      checkOutput("mul.in_ready", 32'(bus.in_ready), 32'h0);
    end
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    waitDrain();
    applyStimulus(mkReq(16'h0011, 16'h0003, 4'b0000, 2'b00, 1'b1, 1'b1),
                  mkExp("mul_no", 16'hFFCC, 1'b0, 1'b1, 1'b0, 1'b0, W + 2));
    waitDrain();
`endif

    repeat (4) @(posedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
